// File: rtl/alu_cmd_issuer_pkg.sv
// Shared types for the ALU command issuer: command function codes, ALU opcodes
// and the mapping between them.
package alu_cmd_issuer_pkg;

  typedef enum logic [2:0] {
    FUNC_ADD = 3'd0,
    FUNC_SUB = 3'd1,
    FUNC_AND = 3'd2,
    FUNC_OR  = 3'd3,
    FUNC_SLL = 3'd4,
    FUNC_ROR = 3'd5,
    FUNC_NOP = 3'd6,
    FUNC_ILL = 3'd7
  } cmd_func_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  // Arithmetic/logic functions map 1:1 onto ALU opcodes; NOP and illegal never
  // enable the ALU, so the opcode driven for them is irrelevant.
  function automatic logic [2:0] func_to_op(cmd_func_e f);
    logic [2:0] op;
    case (f)
      FUNC_ADD: op = OP_ADD;
      FUNC_SUB: op = OP_SUB;
      FUNC_AND: op = OP_AND;
      FUNC_OR:  op = OP_OR;
      FUNC_SLL: op = OP_SLL;
      FUNC_ROR: op = OP_ROR;
      default:  op = OP_ADD;
    endcase
    return op;
  endfunction

  function automatic logic func_uses_alu(cmd_func_e f);
    return (f <= FUNC_ROR);
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU and result bus of the ALU command issuer.
// master = issuer side, slave = command producer / ALU / result consumer side.
interface alu_cmd_issuer_if #(
  parameter int DataSize  = 32,
  parameter int ALUopSize = 3,
  parameter int TagSize   = 4
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_func;
  logic [DataSize-1:0]  cmd_a;
  logic [DataSize-1:0]  cmd_b;
  logic [TagSize-1:0]   cmd_tag;

  logic [ALUopSize-1:0] alu_op;
  logic [DataSize-1:0]  alu_src1;
  logic [DataSize-1:0]  alu_src2;
  logic                 alu_enable;
  logic [DataSize-1:0]  alu_result;
  logic                 alu_overflow;

  logic                 res_valid;
  logic                 res_ready;
  logic [DataSize-1:0]  res_data;
  logic                 res_ovf;
  logic                 res_err;
  logic [TagSize-1:0]   res_tag;

  modport master (
    input  cmd_valid, cmd_func, cmd_a, cmd_b, cmd_tag,
    input  alu_result, alu_overflow, res_ready,
    output cmd_ready, alu_op, alu_src1, alu_src2, alu_enable,
    output res_valid, res_data, res_ovf, res_err, res_tag
  );

  modport slave (
    output cmd_valid, cmd_func, cmd_a, cmd_b, cmd_tag,
    output alu_result, alu_overflow, res_ready,
    input  cmd_ready, alu_op, alu_src1, alu_src2, alu_enable,
    input  res_valid, res_data, res_ovf, res_err, res_tag
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Initiator for a combinational ALU: two-stage pipeline (issue, capture) with
// valid/ready on both ends, sticky overflow flag and retired-op counter.
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int DataSize  = 32,
  parameter int ALUopSize = 3,
  parameter int TagSize   = 4,
  parameter int CntSize   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_cmd_issuer_if.master   bus,
  input  logic               clr_sticky,
  output logic               sticky_ovf,
  output logic [CntSize-1:0] op_count
);

  cmd_func_e            func;
  logic                 s1_adv;
  logic                 accept;
  logic                 retire;

  logic                 s1_vld_q;
  logic                 s1_en_q;
  logic                 s1_err_q;
  logic [ALUopSize-1:0] s1_op_q;
  logic [DataSize-1:0]  s1_src1_q;
  logic [DataSize-1:0]  s1_src2_q;
  logic [TagSize-1:0]   s1_tag_q;

  logic                 s2_vld_q;
  logic                 s2_ovf_q;
  logic                 s2_err_q;
  logic [DataSize-1:0]  s2_data_q;
  logic [TagSize-1:0]   s2_tag_q;

  logic                 sticky_q, sticky_d;
  logic [CntSize-1:0]   cnt_q, cnt_d;

  assign func   = cmd_func_e'(bus.cmd_func);
  // S1 may move forward when S2 is empty or S2 is being drained this edge.
  assign s1_adv = s1_vld_q && (!s2_vld_q || bus.res_ready);
  assign bus.cmd_ready = rst_n && (!s1_vld_q || s1_adv);
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign retire = s2_vld_q && bus.res_ready;

  // Issue stage: latch the accepted command and hold it on the ALU ports.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_en_q   <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_op_q   <= '0;
      s1_src1_q <= '0;
      s1_src2_q <= '0;
      s1_tag_q  <= '0;
    end else if (accept) begin
      s1_vld_q  <= 1'b1;
      s1_en_q   <= func_uses_alu(func);
      s1_err_q  <= (func == FUNC_ILL);
      s1_op_q   <= ALUopSize'(func_to_op(func));
      s1_src1_q <= bus.cmd_a;
      s1_src2_q <= bus.cmd_b;
      s1_tag_q  <= bus.cmd_tag;
    end else if (s1_adv) begin
      s1_vld_q  <= 1'b0;
    end
  end

  // Capture stage: sample the ALU outputs; NOP/illegal ops yield zero result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      s2_ovf_q  <= 1'b0;
      s2_err_q  <= 1'b0;
      s2_data_q <= '0;
      s2_tag_q  <= '0;
    end else if (s1_adv) begin
      s2_vld_q  <= 1'b1;
      s2_data_q <= s1_en_q ? bus.alu_result : '0;
      s2_ovf_q  <= s1_en_q & bus.alu_overflow;
      s2_err_q  <= s1_err_q;
      s2_tag_q  <= s1_tag_q;
    end else if (retire) begin
      s2_vld_q  <= 1'b0;
    end
  end

  // Retire bookkeeping: a retiring overflow beats a simultaneous clear.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (retire) cnt_d = cnt_q + CntSize'(1);
    if (retire && s2_ovf_q) sticky_d = 1'b1;
    else if (clr_sticky)    sticky_d = 1'b0;
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.alu_op     = s1_op_q;
  assign bus.alu_src1   = s1_src1_q;
  assign bus.alu_src2   = s1_src2_q;
  assign bus.alu_enable = s1_vld_q && s1_en_q;

  assign bus.res_valid  = s2_vld_q;
  assign bus.res_data   = s2_data_q;
  assign bus.res_ovf    = s2_ovf_q;
  assign bus.res_err    = s2_err_q;
  assign bus.res_tag    = s2_tag_q;

  assign sticky_ovf     = sticky_q;
  assign op_count       = cnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Testbench for alu_cmd_issuer: directed scenarios plus randomized traffic,
// scored against an in-order queue of results computed from the command alone.
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_sticky = 1'b0;
  logic        sticky_ovf;
  logic [15:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_cnt = '0;
  logic        m_sticky = 1'b0;
  bit          started = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.DataSize(32), .ALUopSize(3), .TagSize(4)) ifc();

  alu_cmd_issuer #(.DataSize(32), .ALUopSize(3), .TagSize(4), .CntSize(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifc),
    .clr_sticky (clr_sticky),
    .sticky_ovf (sticky_ovf),
    .op_count   (op_count)
  );

  // Stand-in for the combinational ALU that sits beside the issuer.
  always_comb begin
    logic signed [32:0] s;
    logic [4:0] sh;
    ifc.alu_result   = '0;
    ifc.alu_overflow = 1'b0;
    s  = '0;
    sh = ifc.alu_src2[4:0];
    if (ifc.alu_enable) begin
      case (ifc.alu_op)
        3'b000: begin
          s = $signed({ifc.alu_src1[31], ifc.alu_src1}) + $signed({ifc.alu_src2[31], ifc.alu_src2});
          ifc.alu_result = s[31:0]; ifc.alu_overflow = s[32] ^ s[31];
        end
        3'b001: begin
          s = $signed({ifc.alu_src1[31], ifc.alu_src1}) - $signed({ifc.alu_src2[31], ifc.alu_src2});
          ifc.alu_result = s[31:0]; ifc.alu_overflow = s[32] ^ s[31];
        end
        3'b010: ifc.alu_result = ifc.alu_src1 & ifc.alu_src2;
        3'b011: ifc.alu_result = ifc.alu_src1 | ifc.alu_src2;
        3'b100: ifc.alu_result = ifc.alu_src1 << sh;
        3'b101: ifc.alu_result = (ifc.alu_src1 >> sh) | (ifc.alu_src1 << (6'd32 - {1'b0, sh}));
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outcome of a command, from the function table alone.
  function automatic exp_t ref_op(logic [2:0] f, logic [31:0] a, logic [31:0] b, logic [3:0] t);
    exp_t e;
    logic [63:0] dbl;
    e.data = '0; e.ovf = 1'b0; e.err = (f == 3'd7); e.tag = t;
    dbl = {a, a} >> b[4:0];
    case (f)
      3'd0: begin e.data = a + b; e.ovf = (a[31] == b[31]) && (e.data[31] != a[31]); end
      3'd1: begin e.data = a - b; e.ovf = (a[31] != b[31]) && (e.data[31] != a[31]); end
      3'd2: e.data = a & b;
      3'd3: e.data = a | b;
      3'd4: e.data = a << b[4:0];
      3'd5: e.data = dbl[31:0];
      default: ;
    endcase
    return e;
  endfunction

  // Scoreboard: looks at the handshakes that will fire on the coming rising edge.
  always @(negedge clk) begin
    exp_t e;
    logic ovf_r;
    ovf_r = 1'b0;
    if (!rst_n) begin
      if (started) chk("rst_cmd_ready", ifc.cmd_ready, 0);
      exp_q.delete();
      m_cnt    = '0;
      m_sticky = 1'b0;
      started  = 1'b1;
    end else if (started) begin
      chk("op_count", op_count, m_cnt);
      chk("sticky_ovf", sticky_ovf, m_sticky);
      if (ifc.res_valid) begin
        if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
        else begin
          e = exp_q[0];
          chk("res_data", ifc.res_data, e.data);
          chk("res_ovf", ifc.res_ovf, e.ovf);
          chk("res_err", ifc.res_err, e.err);
          chk("res_tag", ifc.res_tag, e.tag);
        end
      end
      if (ifc.res_valid && ifc.res_ready && exp_q.size() > 0) begin
        ovf_r = exp_q[0].ovf;
        void'(exp_q.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (ovf_r) m_sticky = 1'b1;
      else if (clr_sticky) m_sticky = 1'b0;
      if (ifc.cmd_valid && ifc.cmd_ready)
        exp_q.push_back(ref_op(ifc.cmd_func, ifc.cmd_a, ifc.cmd_b, ifc.cmd_tag));
    end
  end

  // Present one command and hold it until accepted; returns at accept edge + 1.
  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] t, output int waits);
    logic rdy;
    rdy = 1'b0;
    waits = 0;
    ifc.cmd_valid = 1'b1; ifc.cmd_func = f; ifc.cmd_a = a; ifc.cmd_b = b; ifc.cmd_tag = t;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk); rdy = ifc.cmd_ready;
      @(posedge clk); #1;
      if (rdy) break;
      waits++;
    end
    if (!rdy) chk("send_accept", rdy, 1);
    ifc.cmd_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 31));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int w;
    bit rdone;
    bit filled;
    ifc.cmd_valid = 1'b1; ifc.cmd_func = 3'd0; ifc.cmd_a = 32'd1; ifc.cmd_b = 32'd1;
    ifc.cmd_tag = 4'd0; ifc.res_ready = 1'b1;

    // Reset held with a pending command
    repeat (3) @(posedge clk);
    #1;
    chk("t1_cmd_ready", ifc.cmd_ready, 0);
    chk("t1_res_valid", ifc.res_valid, 0);
    chk("t1_op_count", op_count, 0);
    chk("t1_sticky", sticky_ovf, 0);
    chk("t1_alu_en", ifc.alu_enable, 0);
    ifc.cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Overflowing ADD and two-edge latency
    send(3'd0, 32'h7FFF_FFFF, 32'h1, 4'd3, w);
    chk("t2_lat_not_yet", ifc.res_valid, 0);
    @(posedge clk); #1;
    chk("t2_res_valid", ifc.res_valid, 1);
    chk("t2_res_data", ifc.res_data, 32'h8000_0000);
    chk("t2_res_ovf", ifc.res_ovf, 1);
    chk("t2_res_tag", ifc.res_tag, 3);
    @(posedge clk); #1;
    chk("t2_sticky", sticky_ovf, 1);
    chk("t2_count", op_count, 1);

    // Back-to-back stream at full rate
    send(3'd1, 32'd5, 32'd7, 4'd1, w);
    chk("t3_wait0", w, 0);
    send(3'd2, 32'h0000_F0F0, 32'h0000_FF00, 4'd2, w);
    chk("t3_wait1", w, 0);
    send(3'd5, 32'h1, 32'h1, 4'd4, w);
    chk("t3_wait2", w, 0);
    chk("t3_and", ifc.res_data, 32'h0000_F000);
    @(posedge clk); #1;
    chk("t3_ror", ifc.res_data, 32'h8000_0000);
    @(posedge clk); #1;
    chk("t3_count", op_count, 4);
    chk("t3_drained", ifc.res_valid, 0);

    // Backpressure: two accepted, third stalls until the consumer is ready
    ifc.res_ready = 1'b0;
    send(3'd3, 32'h0F, 32'hF0, 4'd1, w);
    send(3'd4, 32'h1, 32'd4, 4'd2, w);
    chk("t4_c2_wait", w, 0);
    fork
      send(3'd0, 32'd1, 32'd2, 4'd3, w);
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("t4_stall_ready", ifc.cmd_ready, 0);
        chk("t4_hold_valid", ifc.res_valid, 1);
        chk("t4_hold_data", ifc.res_data, 32'hFF);
        chk("t4_hold_tag", ifc.res_tag, 1);
        chk("t4_hold_src1", ifc.alu_src1, 1);
        ifc.res_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("t4_all_retired", exp_q.size(), 0);
    chk("t4_count", op_count, 7);

    // Illegal and NOP commands
    send(3'd7, 32'd9, 32'd9, 4'd5, w);
    chk("t5_ill_alu_en", ifc.alu_enable, 0);
    @(posedge clk); #1;
    chk("t5_ill_err", ifc.res_err, 1);
    chk("t5_ill_data", ifc.res_data, 0);
    send(3'd6, 32'd3, 32'd4, 4'd6, w);
    chk("t5_nop_alu_en", ifc.alu_enable, 0);
    @(posedge clk); #1;
    chk("t5_nop_err", ifc.res_err, 0);
    chk("t5_nop_data", ifc.res_data, 0);
    chk("t5_nop_tag", ifc.res_tag, 6);

    // Sticky flag: set beats clear on the same edge
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    chk("t6_clr", sticky_ovf, 0);
    ifc.res_ready = 1'b0;
    send(3'd0, 32'h8000_0000, 32'h8000_0000, 4'd7, w);
    @(posedge clk); #1;
    chk("t6_ovf_ready", ifc.res_ovf, 1);
    ifc.res_ready = 1'b1;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    chk("t6_set_wins", sticky_ovf, 1);
    @(posedge clk); #1;
    chk("t6_clr_alone", sticky_ovf, 0);
    clr_sticky = 1'b0;

    // Randomized traffic with random consumer stalls and clears
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 4'($urandom), w);
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          ifc.res_ready = ($urandom_range(0, 3) != 0);
          clr_sticky    = ($urandom_range(0, 15) == 0);
        end
      end
    join
    ifc.res_ready = 1'b1;
    clr_sticky = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rand_all_retired", exp_q.size(), 0);

    // Reset with ops in flight discards them
    ifc.res_ready = 1'b0;
    send(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd8, w);
    send(3'd1, 32'd1, 32'd2, 4'd9, w);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_res_valid", ifc.res_valid, 0);
    chk("mid_rst_count", op_count, 0);
    rst_n = 1'b1;
    ifc.res_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_res_valid", ifc.res_valid, 0);
    chk("post_rst_cmd_ready", ifc.cmd_ready, 1);

    // Counter wrap: fill to all-ones with NOPs, then one more
    filled = 1'b0;
    ifc.cmd_valid = 1'b1; ifc.cmd_func = 3'd6; ifc.cmd_a = '0; ifc.cmd_b = '0; ifc.cmd_tag = 4'd0;
    for (int n = 0; n < 70000; n++) begin
      @(posedge clk); #1;
      if (int'(m_cnt) + exp_q.size() >= 65535) begin
        ifc.cmd_valid = 1'b0;
        filled = 1'b1;
        break;
      end
    end
    ifc.cmd_valid = 1'b0;
    if (!filled) chk("wrap_fill_done", filled, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("wrap_full", op_count, 16'hFFFF);
    send(3'd6, 32'd0, 32'd0, 4'd1, w);
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_zero", op_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
